mem_bank: RTL and testbench

MEM_BANK -- requirements
Module: mem_bank

---
 rtl/mem_bank_pkg.sv | 13 +
 rtl/mem_bank.sv | 64 ++++++
 tb/tb_mem_bank.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_bank_pkg.sv
// rtl/mem_bank_pkg.sv - shared defaults and address range helper for mem_bank
package mem_bank_pkg;

  localparam int unsigned MB_DATA_W = 32;
  localparam int unsigned MB_DEPTH  = 64;
  localparam int unsigned MB_ADDR_W = 8;

  // The full address is compared, so addresses at or above DEPTH never alias low words.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mem_bank.sv
// rtl/mem_bank.sv - word-addressed register-array memory, registered read, read-before-write
module mem_bank
  import mem_bank_pkg::*;
#(
  parameter int unsigned DATA_W = MB_DATA_W,
  parameter int unsigned DEPTH  = MB_DEPTH,
  parameter int unsigned ADDR_W = MB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [DEPTH-1:0][DATA_W-1:0] store_t;

  function automatic store_t identity_image();
    store_t img;
    for (int i = 0; i < DEPTH; i++) begin
      img[IDX_W'(i)] = DATA_W'(i);
    end
    return img;
  endfunction

  // Power-up contents match the reset image so reads are defined before the first reset.
  store_t            mem_q = identity_image();
  store_t            mem_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic [IDX_W-1:0]  idx;
  logic              in_range;

  assign idx      = IDX_W'(address);
  assign in_range = addr_in_range(32'(address), DEPTH);

  // Reads sample mem_q, so a same-address write is only seen by later reads.
  always_comb begin
    mem_d      = mem_q;
    readdata_d = readdata_q;
    if (memread) begin
      readdata_d = in_range ? mem_q[idx] : '0;
    end
    if (memwrite && in_range) begin
      mem_d[idx] = writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q      <= identity_image();
      readdata_q <= '0;
    end else begin
      mem_q      <= mem_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_mem_bank.sv
// tb/tb_mem_bank.sv - randomized and directed self-checking bench for mem_bank
module tb_mem_bank;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              memread = 1'b0;
  logic              memwrite = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [DATA_W-1:0] writedata = '0;
  logic [DATA_W-1:0] readdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] model_rd;

  mem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .memread  (memread),
    .memwrite (memwrite),
    .address  (address),
    .writedata(writedata),
    .readdata (readdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = DATA_W'(i);
    model_rd = '0;
  endtask

  // One clock edge; the model applies the access rules directly, then readdata is compared.
  task automatic step(input string tag, input logic rst, input logic rd, input logic wr,
                      input int addr, input logic [DATA_W-1:0] wdata, input logic do_check);
    reset     = rst;
    memread   = rd;
    memwrite  = wr;
    address   = ADDR_W'(addr);
    writedata = wdata;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (rd) model_rd = (addr < DEPTH) ? model_mem[addr] : '0;
      if (wr && addr < DEPTH) model_mem[addr] = wdata;
    end
    #1;
    if (do_check) check(tag, readdata, model_rd);
    reset    = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    step("preinit_rd7", 0, 1, 0, 7, '0, 1);
    check("preinit_rd7_const", readdata, 32'd7);

    step("reset", 1, 0, 0, 0, '0, 1);
    check("reset_const", readdata, 32'd0);

    for (int a = 0; a < DEPTH; a++) begin
      step("sweep_rd", 0, 1, 0, a, '0, 1);
      if (readdata !== DATA_W'(a)) check("sweep_rd_const", readdata, DATA_W'(a));
    end

    step("wr5", 0, 0, 1, 5, 32'hDEADBEEF, 1);
    step("rd5", 0, 1, 0, 5, '0, 1);
    check("rd5_const", readdata, 32'hDEADBEEF);
    step("rd4", 0, 1, 0, 4, '0, 1);
    check("rd4_const", readdata, 32'd4);
    step("rd6", 0, 1, 0, 6, '0, 1);
    check("rd6_const", readdata, 32'd6);

    step("rbw10", 0, 1, 1, 10, 32'h12345678, 1);
    check("rbw10_old", readdata, 32'd10);
    step("rd10", 0, 1, 0, 10, '0, 1);
    check("rd10_new", readdata, 32'h12345678);

    step("rw_diff", 0, 1, 1, 20, 32'hCAFE0001, 1);
    check("rw_diff_rd", readdata, 32'd20);
    step("rd20", 0, 1, 0, 20, '0, 1);
    check("rd20_new", readdata, 32'hCAFE0001);

    step("rd64", 0, 1, 0, 64, '0, 1);
    check("rd64_const", readdata, 32'd0);
    step("rd1", 0, 1, 0, 1, '0, 1);
    step("rd127", 0, 1, 0, 127, '0, 1);
    check("rd127_const", readdata, 32'd0);
    step("wr64", 0, 0, 1, 64, 32'hFFFFFFFF, 1);
    step("rd0", 0, 1, 0, 0, '0, 1);
    check("rd0_noalias", readdata, 32'd0);

    step("rd9", 0, 1, 0, 9, '0, 1);
    for (int a = 0; a < 128; a++) begin
      step("hold", 0, 0, 0, a, 32'h55555555, 0);
      if (readdata !== 32'd9) check("hold_const", readdata, 32'd9);
    end
    check("hold_end", readdata, 32'd9);

    step("wr3", 0, 0, 1, 3, 32'hAA, 1);
    step("rd3_pre", 0, 1, 0, 3, '0, 1);
    check("rd3_pre_const", readdata, 32'hAA);
    step("reset_wr", 1, 1, 1, 3, 32'hBB, 1);
    check("reset_wr_const", readdata, 32'd0);
    step("rd3_post", 0, 1, 0, 3, '0, 1);
    check("rd3_post_const", readdata, 32'd3);

    for (int n = 0; n < 600; n++) begin
      logic rst, rd, wr;
      int   addr;
      rst  = ($urandom_range(0, 49) == 0);
      rd   = $urandom_range(0, 1);
      wr   = $urandom_range(0, 1);
      addr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, DEPTH - 1);
      step("rand", rst, rd, wr, addr, $urandom, 1);
    end

    for (int a = 0; a < DEPTH; a++) step("final_rd", 0, 1, 0, a, '0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
